// File: rtl/quiz_arbiter_ctrl.sv
// Quiz key arbiter: registers key edges, runs the round FSM, owns Timer_Start and the buzzer pulse.
// Optional feature: define FOUL_LOCKOUT_EN to bar a fouling player from the following round.
module quiz_arbiter_ctrl #(
  parameter int N_PLAYERS   = 4,
  parameter int ID_W        = 3,
  parameter int BEEP_CYCLES = 8
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Host_Start,
  input  logic                 Host_Clear,
  input  logic [N_PLAYERS-1:0] Player_Key,
  input  logic                 Timer_Zero,
  output logic                 Timer_Start,
  output logic [ID_W-1:0]      Winner_ID,
  output logic [N_PLAYERS-1:0] Player_LED,
  output logic                 Foul_Flag,
  output logic                 Time_Up,
  output logic                 Buzzer_Out
);

  localparam int CNT_W = $clog2(BEEP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_ANSWER,
    S_FOUL,
    S_TIMEOUT
  } state_t;

  state_t                 state, state_nxt;
  logic [N_PLAYERS-1:0]   key_q;
  logic [N_PLAYERS-1:0]   rise_q;
  logic [N_PLAYERS-1:0]   elig_rise;
  logic [ID_W-1:0]        winner_q, winner_nxt;
  logic [ID_W-1:0]        first_id;
  logic [CNT_W-1:0]       beep_cnt, beep_nxt;
  logic                   event_entry;

  // Edge detector: rise_q is a registered pulse, giving the two-cycle key-to-winner latency.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      key_q  <= '0;
      rise_q <= '0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every register samples pre-edge values.
      key_q  <= Player_Key;
      rise_q <= Player_Key & ~key_q;
    end
  end

`ifdef FOUL_LOCKOUT_EN
  logic [N_PLAYERS-1:0] lock_mask, lock_nxt;

  assign elig_rise = rise_q & ~lock_mask;

  always_comb begin
    lock_nxt = lock_mask;
    if (!Host_Clear) begin
      if (state == S_IDLE && state_nxt == S_FOUL) begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (first_id == ID_W'(i + 1)) lock_nxt[i] = 1'b1;
        end
      end else if (state == S_ARMED && state_nxt != S_ARMED) begin
        lock_nxt = '0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) lock_mask <= '0;
    else       lock_mask <= lock_nxt;
  end
`else
  assign elig_rise = rise_q;
`endif

  // Lowest index wins among simultaneous rises; the rest are dropped.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    first_id = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (elig_rise[i]) first_id = ID_W'(i + 1);
    end
  end

  // A registered rise meeting Timer_Zero in ARMED is the key-vs-timeout race; the key wins.
  always_comb begin
    state_nxt   = state;
    winner_nxt  = winner_q;
    event_entry = 1'b0;
    if (Host_Clear) begin
      state_nxt  = S_IDLE;
      winner_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|elig_rise) begin
            state_nxt   = S_FOUL;
            winner_nxt  = first_id;
            event_entry = 1'b1;
          end else if (Host_Start) begin
            state_nxt = S_ARMED;
          end
        end
        S_ARMED: begin
          if (|elig_rise) begin
            state_nxt   = S_ANSWER;
            winner_nxt  = first_id;
            event_entry = 1'b1;
          end else if (Timer_Zero) begin
            state_nxt   = S_TIMEOUT;
            winner_nxt  = '0;
            event_entry = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    beep_nxt = beep_cnt;
    if (Host_Clear)            beep_nxt = '0;
    else if (event_entry)      beep_nxt = CNT_W'(BEEP_CYCLES);
    else if (beep_cnt != '0)   beep_nxt = beep_cnt - 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= S_IDLE;
      winner_q <= '0;
      beep_cnt <= '0;
    end else begin
      state    <= state_nxt;
      winner_q <= winner_nxt;
      beep_cnt <= beep_nxt;
    end
  end

  // Outputs decode registered state only, so they clear the moment RSTn falls.
  always_comb begin
    Player_LED = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      Player_LED[i] = (winner_q == ID_W'(i + 1));
    end
  end

  assign Winner_ID   = winner_q;
  assign Timer_Start = (state == S_ARMED);
  assign Foul_Flag   = (state == S_FOUL);
  assign Time_Up     = (state == S_TIMEOUT);
  assign Buzzer_Out  = (beep_cnt != '0);

endmodule

// File: tb/tb_quiz_arbiter_ctrl.sv
// Directed bench for quiz_arbiter_ctrl (N_PLAYERS=4, BEEP_CYCLES=4); honours FOUL_LOCKOUT_EN if defined.
module tb_quiz_arbiter_ctrl;

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       Host_Start, Host_Clear, Timer_Zero;
  logic [3:0] Player_Key;
  logic       Timer_Start, Foul_Flag, Time_Up, Buzzer_Out;
  logic [2:0] Winner_ID;
  logic [3:0] Player_LED;

  int checks   = 0;
  int failures = 0;
  int beeps;

  quiz_arbiter_ctrl #(.N_PLAYERS(4), .ID_W(3), .BEEP_CYCLES(4)) dut (
    .CLK(CLK), .RSTn(RSTn), .Host_Start(Host_Start), .Host_Clear(Host_Clear),
    .Player_Key(Player_Key), .Timer_Zero(Timer_Zero), .Timer_Start(Timer_Start),
    .Winner_ID(Winner_ID), .Player_LED(Player_LED), .Foul_Flag(Foul_Flag),
    .Time_Up(Time_Up), .Buzzer_Out(Buzzer_Out)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    Host_Start = 1'b1; step(); Host_Start = 1'b0;
  endtask

  task automatic pulse_clear();
    Host_Clear = 1'b1; step(); Host_Clear = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, Timer_Start, 0);
    check({tag, "_id"},    Winner_ID,   0);
    check({tag, "_led"},   Player_LED,  0);
    check({tag, "_foul"},  Foul_Flag,   0);
    check({tag, "_tup"},   Time_Up,     0);
    check({tag, "_buzz"},  Buzzer_Out,  0);
  endtask

  initial begin
    RSTn = 1'b0; Host_Start = 1'b0; Host_Clear = 1'b0; Timer_Zero = 1'b0; Player_Key = 4'b0;
    step(); step();
    check_all_zero("reset");
    RSTn = 1'b1;
    step();

    // Plain answer by key[2], full beep length, Host_Start ignored while answering.
    pulse_start();
    check("t1_armed", Timer_Start, 1);
    Player_Key = 4'b0100; step();
    check("t1_lat1_start", Timer_Start, 1);
    check("t1_lat1_id", Winner_ID, 0);
    step();
    check("t1_id", Winner_ID, 3);
    check("t1_led", Player_LED, 4'b0100);
    check("t1_start", Timer_Start, 0);
    beeps = 0;
    for (int i = 0; i < 7; i++) begin
      beeps += int'(Buzzer_Out);
      step();
    end
    check("t1_beep_len", beeps, 4);
    pulse_start();
    check("t5_start_ignored_start", Timer_Start, 0);
    check("t5_start_ignored_id", Winner_ID, 3);
    Player_Key = 4'b0;
    pulse_clear();
    check_all_zero("t1_clear");

    // Simultaneous rises on keys 1 and 3; a later key[3] rise is ignored.
    pulse_start();
    Player_Key = 4'b1010; step(); step();
    check("t2_id", Winner_ID, 2);
    check("t2_led", Player_LED, 4'b0010);
    Player_Key = 4'b0010; step();
    Player_Key = 4'b1010; step(); step();
    check("t2_late_id", Winner_ID, 2);
    Player_Key = 4'b0;
    pulse_clear();

    // Early press in IDLE is a foul by key[0].
    Player_Key = 4'b0001; step(); step();
    check("t3_foul", Foul_Flag, 1);
    check("t3_id", Winner_ID, 1);
    check("t3_led", Player_LED, 4'b0001);
    check("t3_start", Timer_Start, 0);
    check("t3_buzz", Buzzer_Out, 1);
    Player_Key = 4'b0;
    pulse_clear();
    check_all_zero("t3_clear");

    // Timer expiry with no key.
    pulse_start();
    Timer_Zero = 1'b1; step();
    check("t4_tup", Time_Up, 1);
    check("t4_id", Winner_ID, 0);
    check("t4_start", Timer_Start, 0);
    check("t4_buzz", Buzzer_Out, 1);
    Timer_Zero = 1'b0;
    pulse_clear();
    check("t4_clear_tup", Time_Up, 0);

    // Registered key edge arriving together with Timer_Zero: key wins.
    pulse_start();
    Player_Key = 4'b0100; step();
    Timer_Zero = 1'b1; step();
    check("t4_race_id", Winner_ID, 3);
    check("t4_race_tup", Time_Up, 0);
    Timer_Zero = 1'b0; Player_Key = 4'b0;
    pulse_clear();

    // Host_Clear beats a key edge in IDLE.
    Player_Key = 4'b0010; step();
    Host_Clear = 1'b1; step(); Host_Clear = 1'b0;
    check("clr_beats_key_foul", Foul_Flag, 0);
    step();
    check("held_key_no_foul", Foul_Flag, 0);
    Player_Key = 4'b0; step();

    // Asynchronous reset in the middle of an answer and its beep.
    pulse_start();
    Player_Key = 4'b0001; step(); step(); step();
    check("t5_pre_buzz", Buzzer_Out, 1);
    #2 RSTn = 1'b0;
    #1;
    check_all_zero("t5_async");
    Player_Key = 4'b0;
    step();
    RSTn = 1'b1;
    step();

    // Lockout: fouling player barred from the next round only.
    Player_Key = 4'b0010; step(); step();
    check("t6_foul_id", Winner_ID, 2);
    Player_Key = 4'b0;
    pulse_clear();
    pulse_start();
    Player_Key = 4'b0010; step(); step();
`ifdef FOUL_LOCKOUT_EN
    check("t6_locked_start", Timer_Start, 1);
    check("t6_locked_id", Winner_ID, 0);
    Player_Key = 4'b0011; step(); step();
    check("t6_other_id", Winner_ID, 1);
    Player_Key = 4'b0;
    pulse_clear();
    pulse_start();
    Player_Key = 4'b0010; step(); step();
    check("t6_next_round_id", Winner_ID, 2);
`else
    check("t6_nolock_id", Winner_ID, 2);
    check("t6_nolock_start", Timer_Start, 0);
`endif
    Player_Key = 4'b0;
    pulse_clear();
    check_all_zero("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
